// File: rtl/prod_accum.sv
// Frame accumulator for signed multiplier products: sums up to N_ACC beats,
// rounds, shifts and saturates the frame sum, and queues results in a 2-entry FIFO.
module prod_accum #(
  parameter int P_WIDTH   = 36,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 18,
  parameter int N_ACC     = 16,
  parameter int SHIFT     = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        p_valid,
  input  logic signed [P_WIDTH-1:0]   p,
  input  logic                        p_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic                        overrun
);

  localparam int CNT_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;

  localparam logic signed [ACC_WIDTH:0] HALF =
    {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // One extra bit so adding the rounding constant can never overflow.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] s
  );
    logic signed [ACC_WIDTH:0] t;
    t = $signed({s[ACC_WIDTH-1], s}) + HALF;
    return t >>> SHIFT;
  endfunction

  // Returns {sat, data}.
  function automatic logic [OUT_WIDTH:0] saturate(
    input logic signed [ACC_WIDTH:0] r
  );
    if (r > SAT_MAX)
      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    else if (r < SAT_MIN)
      return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    else
      return {1'b0, r[OUT_WIDTH-1:0]};
  endfunction

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;

  logic signed [ACC_WIDTH-1:0]   p_ext;
  logic signed [ACC_WIDTH-1:0]   sum_p0;
  logic                          vld_p0;
  logic [OUT_WIDTH:0]            ent_p0;

  logic [OUT_WIDTH:0]            fifo_q [2];
  logic [1:0]                    fcnt_q;
  logic                          ovr_q;
  logic                          pop;

  // Stage p0: frame sum including the current beat, rounded and clipped.
  assign p_ext  = {{(ACC_WIDTH - P_WIDTH){p[P_WIDTH-1]}}, p};
  assign sum_p0 = (state_q == IDLE) ? p_ext : acc_q + p_ext;
  assign vld_p0 = p_valid && (p_last || (cnt_q == CNT_W'(N_ACC - 1)));
  assign ent_p0 = saturate(round_shift(sum_p0));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (p_valid) state_d = vld_p0 ? IDLE : ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (p_valid) begin
      if (vld_p0) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= sum_p0;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage p1: output FIFO, head always in slot 0.
  assign out_valid = (fcnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_q[0][OUT_WIDTH-1:0];
  assign out_sat   = fifo_q[0][OUT_WIDTH];
  assign overrun   = ovr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      fcnt_q    <= 2'd0;
      ovr_q     <= 1'b0;
    end else begin
      case ({vld_p0, pop})
        2'b10: begin
          if (fcnt_q == 2'd2) begin
            ovr_q <= 1'b1;
          end else begin
            fifo_q[fcnt_q[0]] <= ent_p0;
            fcnt_q            <= fcnt_q + 2'd1;
          end
        end
        2'b01: begin
          fifo_q[0] <= fifo_q[1];
          fcnt_q    <= fcnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (fcnt_q == 2'd2) begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= ent_p0;
          end else begin
            fifo_q[0] <= ent_p0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: directed frames from the requirement list, then random
// traffic, all compared against a queue-based frame model.
module tb_prod_accum;

  localparam int PW = 36;
  localparam int AW = 48;
  localparam int OW = 18;
  localparam int NA = 4;
  localparam int SH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 p_valid;
  logic signed [PW-1:0] p;
  logic                 p_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_sat;
  logic                 overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic signed [OW-1:0] d;
    logic                 s;
  } ent_t;

  ent_t    mq[$];
  longint  m_sum;
  int      m_n;
  logic    m_ovr;

  prod_accum #(
    .P_WIDTH(PW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .N_ACC(NA), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst), .p_valid(p_valid), .p(p), .p_last(p_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame result from plain arithmetic: round half up, shift, clip.
  function automatic ent_t frame_result(input longint s);
    ent_t   e;
    longint r;
    r = (s + (longint'(1) <<< (SH - 1))) >>> SH;
    if (r > 131071)       begin e.d = 18'sd131071;  e.s = 1'b1; end
    else if (r < -131072) begin e.d = -18'sd131072; e.s = 1'b1; end
    else                  begin e.d = OW'(r);       e.s = 1'b0; end
    return e;
  endfunction

  task automatic model(input logic v, input longint pv, input logic last,
                       input logic rdy);
    logic full, popped;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_n = 0; m_sum = 0; m_ovr = 1'b0;
      return;
    end
    full   = (mq.size() == 2);
    popped = (mq.size() > 0) && rdy;
    if (popped) void'(mq.pop_front());
    if (v) begin
      m_sum = (m_n == 0) ? pv : m_sum + pv;
      m_n++;
      if (last || m_n == NA) begin
        e = frame_result(m_sum);
        if (full && !popped) m_ovr = 1'b1;
        else                 mq.push_back(e);
        m_n = 0;
      end
    end
  endtask

  // Inputs are driven at the falling edge, outputs checked at the next one.
  task automatic step(input logic v, input longint pv, input logic last,
                      input logic rdy);
    p_valid = v; p = PW'(pv); p_last = last; out_ready = rdy;
    model(v, pv, last, rdy);
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("overrun", overrun, m_ovr);
    if (mq.size() > 0) begin
      chk("out_data", out_data, mq[0].d);
      chk("out_sat", out_sat, mq[0].s);
    end
  endtask

  task automatic frame4(input longint v, input logic rdy);
    for (int i = 0; i < NA; i++) step(1'b1, v, 1'b0, rdy);
  endtask

  initial begin
    rst = 1'b1; p_valid = 1'b0; p = '0; p_last = 1'b0; out_ready = 1'b0;
    m_sum = 0; m_n = 0; m_ovr = 1'b0;
    @(negedge clk);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;

    // Full frame: four beats of 16.
    step(1'b0, 0, 1'b0, 1'b1);
    frame4(16, 1'b1);
    chk("full_valid", out_valid, 1);
    chk("full_data", out_data, 4);
    chk("full_sat", out_sat, 0);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("full_drained", out_valid, 0);

    // Early end and rounding.
    step(1'b1, 8, 1'b1, 1'b1);
    chk("round_pos", out_data, 1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, -8, 1'b1, 1'b1);
    chk("round_neg", out_data, 0);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1);
    chk("gap_no_out", out_valid, 0);
    step(1'b1, 3, 1'b1, 1'b1);
    chk("gap_data", out_data, 1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Saturation at both rails.
    frame4(longint'(1) <<< 30, 1'b1);
    chk("sat_hi_data", out_data, 131071);
    chk("sat_hi_flag", out_sat, 1);
    frame4(-(longint'(1) <<< 30), 1'b1);
    chk("sat_lo_data", out_data, -131072);
    chk("sat_lo_flag", out_sat, 1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Backpressure: third frame is dropped.
    for (int f = 0; f < 3; f++) frame4(16, 1'b0);
    chk("bp_ovr", overrun, 1);
    chk("bp_data", out_data, 4);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("bp_second", out_valid, 1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("bp_empty", out_valid, 0);
    chk("bp_ovr_sticky", overrun, 1);

    // Reset mid-frame, with a beat on the reset cycle itself.
    step(1'b1, 1000, 1'b0, 1'b1);
    step(1'b1, 1000, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b1, 1000, 1'b0, 1'b1);
    rst = 1'b0;
    chk("mid_rst_ovr", overrun, 0);
    frame4(16, 1'b1);
    chk("mid_rst_data", out_data, 4);
    step(1'b0, 0, 1'b0, 1'b1);

    // FIFO full, frame closes on the same edge as a pop.
    frame4(32, 1'b0);
    frame4(48, 1'b0);
    for (int i = 0; i < NA - 1; i++) step(1'b1, 64, 1'b0, 1'b0);
    chk("full_head", out_data, 8);
    step(1'b1, 64, 1'b0, 1'b1);
    chk("pushpop_ovr", overrun, 0);
    chk("pushpop_2nd", out_data, 12);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("pushpop_3rd", out_data, 16);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("pushpop_empty", out_valid, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [PW-1:0] r36;
      longint        pv;
      r36 = PW'({$urandom, $urandom});
      if ($urandom_range(0, 1) == 0) pv = longint'($urandom_range(0, 4000)) - 2000;
      else                           pv = longint'($signed(r36));
      rst = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 9) < 7, pv, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 6);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
